// File: rtl/fft_pkg.sv
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared constants and state encoding for the radix-2 FFT scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int unsigned c_LOG2_PTS_DEF = 5;
  // Pipeline latency of the fft_2 butterfly, from data valid to result valid.
  localparam int unsigned c_FFT2_LAT     = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_wr_dly.sv
// ============================================================================
// Module  : fft_wr_dly
// Brief   : DEPTH-stage delay line for the write-back valid and address pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_wr_dly #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  output logic          o_vld,
  output logic [AW-1:0] o_addr0,
  output logic [AW-1:0] o_addr1
);

  localparam int unsigned c_DW = 1 + 2 * AW;

  logic [c_DW-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe[0] <= '0;
    end else begin
      r_pipe[0] <= {i_vld, i_addr0, i_addr1};
    end
  end

  for (genvar g = 1; g < int'(DEPTH); g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pipe[g] <= '0;
      end else begin
        r_pipe[g] <= r_pipe[g-1];
      end
    end
  end

  assign {o_vld, o_addr0, o_addr1} = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fft_r2_sched.sv
// ============================================================================
// Module  : fft_r2_sched
// Brief   : In-place radix-2 DIT FFT address/control scheduler for one fft_2.
//           Optional FFT_R2_SCHED_CYCCNT_EN adds the o_cyc_cnt cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_r2_sched
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_PTS = c_LOG2_PTS_DEF,
  parameter int unsigned BF_LAT   = c_FFT2_LAT,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_ifft_in,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_en,
  output logic [LOG2_PTS-1:0] o_rd_addr0,
  output logic [LOG2_PTS-1:0] o_rd_addr1,
  output logic [LOG2_PTS-2:0] o_tw_addr,
  output logic                o_bf_ifft,
  output logic                o_wr_en,
  output logic [LOG2_PTS-1:0] o_wr_addr0,
  output logic [LOG2_PTS-1:0] o_wr_addr1
`ifdef FFT_R2_SCHED_CYCCNT_EN
  ,
  output logic [15:0]         o_cyc_cnt
`endif
);

  localparam int unsigned c_AW   = LOG2_PTS;
  localparam int unsigned c_KW   = LOG2_PTS - 1;
  localparam int unsigned c_PIPE = RD_LAT + BF_LAT;
  localparam int unsigned c_CW   = $clog2(c_PIPE + 1);
  localparam logic [c_AW-1:0] c_KW_V       = c_AW'(c_KW);
  localparam logic [c_AW-1:0] c_LAST_STAGE = c_AW'(LOG2_PTS - 1);
  localparam logic [c_CW-1:0] c_DRN_LAST   = c_CW'(c_PIPE - 1);

  state_t          r_state, w_state_nxt;
  logic [c_KW-1:0] r_k, w_k_nxt;
  logic [c_AW-1:0] r_stage, w_stage_nxt;
  logic [c_CW-1:0] r_drn, w_drn_nxt;
  logic            r_ifft, w_ifft_nxt;

  logic            w_busy, w_done, w_rd;
  logic [c_KW-1:0] w_mask, w_pos;
  logic [c_AW-1:0] w_kx, w_half, w_a0, w_tw_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_drn   <= '0;
      r_ifft  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      r_drn   <= w_drn_nxt;
      r_ifft  <= w_ifft_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_drn_nxt   = r_drn;
    w_ifft_nxt  = r_ifft;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = S_ISSUE;
          w_k_nxt     = '0;
          w_stage_nxt = '0;
          w_ifft_nxt  = i_ifft_in;
        end
      end
      S_ISSUE: begin
        w_rd    = 1'b1;
        w_k_nxt = r_k + 1'b1;
        if (r_k == '1) begin
          w_state_nxt = S_DRAIN;
          w_drn_nxt   = '0;
        end
      end
      S_DRAIN: begin
        // Hold off the next stage until every write of this one has retired.
        w_drn_nxt = r_drn + 1'b1;
        if (r_drn == c_DRN_LAST) begin
          if (r_stage == c_LAST_STAGE) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_stage_nxt = r_stage + 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand 0 address is k with a zero bit inserted at position s.
  always_comb begin
    w_mask  = ~({c_KW{1'b1}} << r_stage);
    w_pos   = r_k & w_mask;
    w_kx    = {1'b0, r_k};
    w_half  = {{(c_AW-1){1'b0}}, 1'b1} << r_stage;
    w_a0    = ((w_kx >> r_stage) << (r_stage + 1'b1)) | {1'b0, w_pos};
    w_tw_sh = c_KW_V - r_stage;
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_rd_en    = w_rd;
  assign o_rd_addr0 = w_rd ? w_a0 : '0;
  assign o_rd_addr1 = w_rd ? (w_a0 + w_half) : '0;
  assign o_tw_addr  = w_rd ? (w_pos << w_tw_sh) : '0;
  assign o_bf_ifft  = r_ifft;

  fft_wr_dly #(
    .DEPTH (c_PIPE),
    .AW    (c_AW)
  ) u_wr_dly (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (o_rd_en),
    .i_addr0 (o_rd_addr0),
    .i_addr1 (o_rd_addr1),
    .o_vld   (o_wr_en),
    .o_addr0 (o_wr_addr0),
    .o_addr1 (o_wr_addr1)
  );

`ifdef FFT_R2_SCHED_CYCCNT_EN
  logic [15:0] r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_cyc_cnt <= '0;
    end else if (w_busy) begin
      r_cyc_cnt <= r_cyc_cnt + 16'd1;
    end
  end

  assign o_cyc_cnt = r_cyc_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_r2_sched.sv
// ============================================================================
// Module  : tb_fft_r2_sched
// Brief   : Directed self-checking bench for fft_r2_sched at default sizing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_r2_sched;

  localparam int c_PIPE = 7;
  localparam int c_SPAN = 23;   // P/2 + PIPE cycles per stage
  localparam int c_DONE = 116;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_ifft_in;
  logic       o_busy, o_done, o_rd_en, o_bf_ifft, o_wr_en;
  logic [4:0] o_rd_addr0, o_rd_addr1, o_wr_addr0, o_wr_addr1;
  logic [3:0] o_tw_addr;
`ifdef FFT_R2_SCHED_CYCCNT_EN
  logic [15:0] o_cyc_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fft_r2_sched u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_ifft_in  (i_ifft_in),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rd_en    (o_rd_en),
    .o_rd_addr0 (o_rd_addr0),
    .o_rd_addr1 (o_rd_addr1),
    .o_tw_addr  (o_tw_addr),
    .o_bf_ifft  (o_bf_ifft),
    .o_wr_en    (o_wr_en),
    .o_wr_addr0 (o_wr_addr0),
    .o_wr_addr1 (o_wr_addr1)
`ifdef FFT_R2_SCHED_CYCCNT_EN
    ,
    .o_cyc_cnt  (o_cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read in cycle c after start: butterfly k of stage s pairs
  // (upper*2*half + lower, +half) with twiddle lower*(16/half).
  task automatic model(input int c, output bit v, output int a0, output int a1, output int tw);
    int t, s, r, half, lo, hi;
    v = 0; a0 = 0; a1 = 0; tw = 0;
    if (c >= 1 && c <= c_DONE - 1) begin
      t = c - 1;
      s = t / c_SPAN;
      r = t % c_SPAN;
      if (r < 16) begin
        half = 1 << s;
        lo   = r % half;
        hi   = r / half;
        a0   = hi * 2 * half + lo;
        a1   = a0 + half;
        tw   = lo * (16 / half);
        v    = 1;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(o_busy), 0);
    chk({tag, ".done"},  32'(o_done), 0);
    chk({tag, ".rd_en"}, 32'(o_rd_en), 0);
    chk({tag, ".wr_en"}, 32'(o_wr_en), 0);
    chk({tag, ".addrs"}, {o_rd_addr0, o_rd_addr1, o_wr_addr0, o_wr_addr1, o_tw_addr}, 0);
  endtask

  task automatic chk_cycle(input int c, input bit ifft);
    bit v, wv;
    int a0, a1, tw, w0, w1, wt;
    model(c, v, a0, a1, tw);
    model(c - c_PIPE, wv, w0, w1, wt);
    chk($sformatf("busy@%0d", c), 32'(o_busy), 32'(c <= c_DONE));
    chk($sformatf("done@%0d", c), 32'(o_done), 32'(c == c_DONE));
    chk($sformatf("rd_en@%0d", c), 32'(o_rd_en), 32'(v));
    chk($sformatf("wr_en@%0d", c), 32'(o_wr_en), 32'(wv));
    chk($sformatf("bf_ifft@%0d", c), 32'(o_bf_ifft), 32'(ifft));
    if (v) begin
      chk($sformatf("rd_addr0@%0d", c), 32'(o_rd_addr0), a0);
      chk($sformatf("rd_addr1@%0d", c), 32'(o_rd_addr1), a1);
      chk($sformatf("tw_addr@%0d", c), 32'(o_tw_addr), tw);
    end
    if (wv) begin
      chk($sformatf("wr_addr0@%0d", c), 32'(o_wr_addr0), w0);
      chk($sformatf("wr_addr1@%0d", c), 32'(o_wr_addr1), w1);
    end
  endtask

  // Called at a negedge; that cycle becomes edge 0 of the transform.
  task automatic run(input bit ifft, input int mid_start, input int rst_at);
    i_start   = 1'b1;
    i_ifft_in = ifft;
    for (int c = 1; c <= c_DONE + 1; c++) begin
      @(negedge clk);
      i_start   = 1'b0;
      i_ifft_in = 1'b0;
      chk_cycle(c, ifft);
      if (c == 4) begin
        chk("s0k3.a0", 32'(o_rd_addr0), 6);
        chk("s0k3.a1", 32'(o_rd_addr1), 7);
      end
      if (c == 52) begin
        chk("s2k5.a0", 32'(o_rd_addr0), 9);
        chk("s2k5.a1", 32'(o_rd_addr1), 13);
        chk("s2k5.tw", 32'(o_tw_addr), 4);
      end
      if (c == 98) begin
        chk("s4k5.a0", 32'(o_rd_addr0), 5);
        chk("s4k5.a1", 32'(o_rd_addr1), 21);
        chk("s4k5.tw", 32'(o_tw_addr), 5);
      end
`ifdef FFT_R2_SCHED_CYCCNT_EN
      if (c == c_DONE + 1) chk("cyc_cnt", 32'(o_cyc_cnt), c_DONE);
`endif
      if (c == mid_start) begin
        i_start   = 1'b1;
        i_ifft_in = ~ifft;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("post_rst");
        chk("post_rst.bf_ifft", 32'(o_bf_ifft), 0);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk_idle($sformatf("after_rst+%0d", i));
        end
        return;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_ifft_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("in_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i));
      chk($sformatf("idle%0d.bf_ifft", i), 32'(o_bf_ifft), 0);
    end

    run(1'b0, 0, 0);     // forward transform
    run(1'b1, 50, 0);    // back-to-back inverse, stray start mid-run
    run(1'b0, 0, 40);    // reset during stage 1
    run(1'b1, 0, 0);     // restart from stage 0 after reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
